// File: rtl/stream_writer_if.sv
// Wishbone bus bundle shared by the stream slave port and the SDRAM master port.
// Carries 32-bit data with 4 byte selects plus the classic cti/bte cycle tags.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst,
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack, dat_sm, err, rty
  );

  modport slave (
    input  clk, rst,
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack, dat_sm, err, rty
  );
endinterface

// File: rtl/stream_writer.sv
// Buffers Wishbone stream words in a FIFO and writes them to the SDRAM framebuffer
// at successive pixel addresses, wrapping at the frame size.
module stream_writer #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADR   = 32'h0
) (
  input  logic   sys_clk,
  input  logic   sys_rst_n,
  wshb_if.slave  wshb_ifs,
  wshb_if.master wshb_ifm,
  output logic   frame_done
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int NPIX = HDISP * VDISP;
  localparam int PW   = $clog2(NPIX);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   pix_q;
  logic            full, empty, push, pop, wrap;

  // Interface clocks/resets and the ignored address/select fields are deliberately unused.
  logic unused_sigs;
  assign unused_sigs = ^{wshb_ifs.clk, wshb_ifs.rst, wshb_ifm.clk, wshb_ifm.rst,
                         wshb_ifs.adr, wshb_ifs.sel, wshb_ifs.cti, wshb_ifs.bte,
                         wshb_ifm.dat_sm, wshb_ifm.err, wshb_ifm.rty};

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = wshb_ifs.cyc && wshb_ifs.stb && wshb_ifs.we && !full;
  assign pop     = (state_q == WRITE) && wshb_ifm.ack;
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign wrap    = (pix_q == PW'(NPIX - 1));

  // Writes are back-pressured only while full; reads complete immediately with zero data.
  assign wshb_ifs.ack    = wshb_ifs.cyc && wshb_ifs.stb && (!wshb_ifs.we || !full);
  assign wshb_ifs.dat_sm = 32'h0;
  assign wshb_ifs.err    = 1'b0;
  assign wshb_ifs.rty    = 1'b0;

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= wshb_ifs.dat_ms;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      pix_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= pop && wrap;
      if (pop) pix_q <= wrap ? '0 : pix_q + 1'b1;
    end
  end

  // Stay in WRITE across acks while words remain, counting any word arriving this cycle.
  always_comb begin
    state_d         = state_q;
    wshb_ifm.cyc    = 1'b0;
    wshb_ifm.stb    = 1'b0;
    wshb_ifm.we     = 1'b0;
    wshb_ifm.sel    = 4'hF;
    wshb_ifm.cti    = 3'b000;
    wshb_ifm.bte    = 2'b00;
    wshb_ifm.dat_ms = mem[rd_ptr];
    wshb_ifm.adr    = BASE_ADR + (32'(pix_q) << 2);
    case (state_q)
      IDLE: begin
        if (!empty) state_d = WRITE;
      end
      WRITE: begin
        wshb_ifm.cyc = 1'b1;
        wshb_ifm.stb = 1'b1;
        wshb_ifm.we  = 1'b1;
        if (wshb_ifm.ack) state_d = (count_d != '0) ? WRITE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_stream_writer.sv
// Directed bench for stream_writer: a default-frame instance and a tiny 4x2 frame instance,
// with scoreboards of expected SDRAM address/data filled as stream words are accepted.
module tb_stream_writer;
  localparam logic [31:0] BASE_A = 32'h0010_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0200;
  localparam int          NPIX_A = 800 * 480;
  localparam int          NPIX_B = 4 * 2;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready_a = 1'b0;
  logic ready_b = 1'b1;
  logic frame_done_a, frame_done_b;

  int checks = 0;
  int failures = 0;
  int idx_a = 0;
  int idx_b = 0;
  int acks_b = 0;
  int fd_pulses_b = 0;
  int cyc_b = 0;
  int first_ack_b = -1;
  int last_ack_b = -1;
  logic fd_expect_b = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  wshb_if ifs_a (.clk(clk), .rst(!rst_n));
  wshb_if ifm_a (.clk(clk), .rst(!rst_n));
  wshb_if ifs_b (.clk(clk), .rst(!rst_n));
  wshb_if ifm_b (.clk(clk), .rst(!rst_n));

  assign ifm_a.ack    = ifm_a.cyc && ifm_a.stb && ready_a;
  assign ifm_a.err    = 1'b0;
  assign ifm_a.rty    = 1'b0;
  assign ifm_a.dat_sm = 32'h0;
  assign ifm_b.ack    = ifm_b.cyc && ifm_b.stb && ready_b;
  assign ifm_b.err    = 1'b0;
  assign ifm_b.rty    = 1'b0;
  assign ifm_b.dat_sm = 32'h0;

  stream_writer #(.HDISP(800), .VDISP(480), .FIFO_DEPTH(16), .BASE_ADR(BASE_A)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .wshb_ifs(ifs_a.slave), .wshb_ifm(ifm_a.master),
    .frame_done(frame_done_a)
  );

  stream_writer #(.HDISP(4), .VDISP(2), .FIFO_DEPTH(16), .BASE_ADR(BASE_B)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .wshb_ifs(ifs_b.slave), .wshb_ifm(ifm_b.master),
    .frame_done(frame_done_b)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer_a(input logic [31:0] d, output logic took);
    @(negedge clk);
    ifs_a.cyc    = 1'b1;
    ifs_a.stb    = 1'b1;
    ifs_a.we     = 1'b1;
    ifs_a.dat_ms = d;
    ifs_a.adr    = $urandom;
    ifs_a.sel    = 4'($urandom_range(0, 15));
    #1;
    took = ifs_a.ack;
    if (took) begin
      q_a.push_back('{BASE_A + 32'((idx_a % NPIX_A) * 4), d});
      idx_a++;
    end
  endtask

  task automatic offer_b(input logic [31:0] d);
    @(negedge clk);
    ifs_b.cyc    = 1'b1;
    ifs_b.stb    = 1'b1;
    ifs_b.we     = 1'b1;
    ifs_b.dat_ms = d;
    #1;
    check32("b_slave_ack", {31'b0, ifs_b.ack}, 32'd1);
    if (ifs_b.ack) begin
      q_b.push_back('{BASE_B + 32'((idx_b % NPIX_B) * 4), d});
      idx_b++;
    end
  endtask

  task automatic idle_a();
    @(negedge clk);
    ifs_a.cyc = 1'b0;
    ifs_a.stb = 1'b0;
    ifs_a.we  = 1'b0;
    #1;
  endtask

  task automatic idle_b();
    @(negedge clk);
    ifs_b.cyc = 1'b0;
    ifs_b.stb = 1'b0;
    ifs_b.we  = 1'b0;
    #1;
  endtask

  task automatic drain_a(input string tag);
    for (int n = 0; n < 80 && q_a.size() != 0; n++) begin
      @(negedge clk);
      #4;
    end
    check32(tag, 32'(q_a.size()), 32'd0);
  endtask

  task automatic drain_b(input string tag);
    for (int n = 0; n < 80 && q_b.size() != 0; n++) begin
      @(negedge clk);
      #4;
    end
    check32(tag, 32'(q_b.size()), 32'd0);
  endtask

  // Scoreboard for the default instance: every SDRAM ack must match the oldest accepted word.
  always @(negedge clk) begin
    #3;
    if (rst_n && ifm_a.cyc && ifm_a.stb && ifm_a.ack) begin
      checks++;
      assert (q_a.size() != 0) else begin
        failures++;
        $error("FAIL a_unexpected_write: observed adr=%h with empty scoreboard", ifm_a.adr);
      end
      if (q_a.size() != 0) begin
        exp_t e;
        e = q_a.pop_front();
        check32("a_adr", ifm_a.adr, e.adr);
        check32("a_dat", ifm_a.dat_ms, e.dat);
        check32("a_sel_we", {27'b0, ifm_a.sel, ifm_a.we}, {27'b0, 4'hF, 1'b1});
      end
    end
  end

  // Scoreboard for the small-frame instance, plus the frame_done pulse after every 8th ack.
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      acks_b      = 0;
      fd_expect_b = 1'b0;
    end else begin
      cyc_b++;
      check32("b_frame_done", {31'b0, frame_done_b}, {31'b0, fd_expect_b});
      if (frame_done_b) fd_pulses_b++;
      fd_expect_b = 1'b0;
      if (ifm_b.cyc && ifm_b.stb && ifm_b.ack) begin
        checks++;
        assert (q_b.size() != 0) else begin
          failures++;
          $error("FAIL b_unexpected_write: observed adr=%h with empty scoreboard", ifm_b.adr);
        end
        if (q_b.size() != 0) begin
          exp_t e;
          e = q_b.pop_front();
          check32("b_adr", ifm_b.adr, e.adr);
          check32("b_dat", ifm_b.dat_ms, e.dat);
        end
        acks_b++;
        if (first_ack_b < 0) first_ack_b = cyc_b;
        last_ack_b = cyc_b;
        if (acks_b % NPIX_B == 0) fd_expect_b = 1'b1;
      end
    end
  end

  initial begin
    logic took;
    int   nxt;
    ifs_a.cyc = 1'b0; ifs_a.stb = 1'b0; ifs_a.we = 1'b0;
    ifs_a.adr = '0; ifs_a.dat_ms = '0; ifs_a.sel = '0; ifs_a.cti = '0; ifs_a.bte = '0;
    ifs_b.cyc = 1'b0; ifs_b.stb = 1'b0; ifs_b.we = 1'b0;
    ifs_b.adr = '0; ifs_b.dat_ms = '0; ifs_b.sel = 4'hF; ifs_b.cti = '0; ifs_b.bte = '0;

    // Reset state, with a write offered during reset to see the combinational ack.
    @(negedge clk);
    #1;
    check32("rst_cyc_stb_we", {29'b0, ifm_a.cyc, ifm_a.stb, ifm_a.we}, 32'd0);
    check32("rst_frame_done", {31'b0, frame_done_a}, 32'd0);
    check32("rst_err_rty", {30'b0, ifs_a.err, ifs_a.rty}, 32'd0);
    check32("rst_dat_sm", ifs_a.dat_sm, 32'd0);
    offer_a(32'hCAFE_0000, took);
    check32("rst_slave_ack", {31'b0, took}, 32'd1);
    q_a.delete();
    idx_a = 0;
    idle_a();
    @(negedge clk);
    rst_n = 1'b1;

    // Single write: stb two cycles later at BASE, then back to IDLE.
    offer_a(32'hDEAD_BEEF, took);
    check32("single_ack", {31'b0, took}, 32'd1);
    idle_a();
    check32("single_stb_n1", {31'b0, ifm_a.stb}, 32'd0);
    @(negedge clk);
    #1;
    check32("single_stb_n2", {31'b0, ifm_a.stb}, 32'd1);
    check32("single_adr", ifm_a.adr, BASE_A);
    check32("single_dat", ifm_a.dat_ms, 32'hDEAD_BEEF);
    check32("single_sel", {28'b0, ifm_a.sel}, 32'hF);
    check32("single_cti_bte", {27'b0, ifm_a.cti, ifm_a.bte}, 32'd0);
    ready_a = 1'b1;
    @(negedge clk);
    #1;
    check32("single_idle_after", {31'b0, ifm_a.stb}, 32'd0);
    drain_a("single_drain");
    offer_a(32'h1234_5678, took);
    idle_a();
    drain_a("second_drain");

    // Read cycle: immediate ack, zero data, no master activity.
    @(negedge clk);
    ifs_a.cyc = 1'b1; ifs_a.stb = 1'b1; ifs_a.we = 1'b0;
    #1;
    check32("read_ack", {31'b0, ifs_a.ack}, 32'd1);
    check32("read_dat_sm", ifs_a.dat_sm, 32'd0);
    idle_a();
    check32("read_no_stb_1", {31'b0, ifm_a.stb}, 32'd0);
    @(negedge clk);
    #1;
    check32("read_no_stb_2", {31'b0, ifm_a.stb}, 32'd0);

    // Backpressure: SDRAM stalled, 20 offered cycles admit exactly 16 words.
    ready_a = 1'b0;
    nxt = 0;
    for (int c = 0; c < 20; c++) begin
      offer_a(32'hA000_0000 + 32'(nxt), took);
      if (took) nxt++;
    end
    check32("bp_accept_count", 32'(nxt), 32'd16);
    offer_a(32'hA000_0000 + 32'(nxt), took);
    ready_a = 1'b1;
    check32("bp_still_full", {31'b0, took}, 32'd0);
    offer_a(32'hA000_0000 + 32'(nxt), took);
    check32("bp_reassert", {31'b0, took}, 32'd1);
    if (took) nxt++;
    for (int c = 0; c < 40 && nxt < 20; c++) begin
      offer_a(32'hA000_0000 + 32'(nxt), took);
      if (took) nxt++;
    end
    check32("bp_total", 32'(nxt), 32'd20);
    idle_a();
    drain_a("bp_drain");

    // Wrap on the 4x2 frame: nine back-to-back words, the ninth returns to BASE.
    for (int i = 0; i < 9; i++) offer_b(32'hB000_0000 + 32'(i));
    idle_b();
    drain_b("wrap_drain");
    @(negedge clk);
    #4;
    check32("wrap_frame_pulses", 32'(fd_pulses_b), 32'd1);
    check32("wrap_no_bubble", 32'(last_ack_b - first_ack_b), 32'd8);

    // Reset while a write is in flight with five words buffered.
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer_a(32'hC000_0000 + 32'(i), took);
      check32("rstmid_accept", {31'b0, took}, 32'd1);
    end
    idle_a();
    for (int n = 0; n < 10 && !ifm_a.stb; n++) begin
      @(negedge clk);
      #1;
    end
    check32("rstmid_stb_seen", {31'b0, ifm_a.stb}, 32'd1);
    rst_n = 1'b0;
    #1;
    check32("rstmid_cyc_drop", {30'b0, ifm_a.cyc, ifm_a.stb}, 32'd0);
    q_a.delete();
    q_b.delete();
    idx_a = 0;
    idx_b = 0;
    ready_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #1;
      check32("rstmid_fifo_empty", {31'b0, ifm_a.stb}, 32'd0);
    end
    offer_a(32'h5555_AAAA, took);
    check32("rstmid_new_ack", {31'b0, took}, 32'd1);
    idle_a();
    drain_a("rstmid_drain");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
